// File: rtl/expander_graph_dma_mc.sv
// expander_graph_dma_mc
// Multi-channel DMA read-request generator for expander-graph encoding.
// NUM_CH row streams share one request port. A round-robin arbiter picks the
// channel, outstanding responses are counted, and completion is reported
// once every issued beat has come back.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start_i           launch a transfer (sampled only in IDLE)
//   ch_en_i           per-channel enable, latched at start
//   base_addr_i       per-channel base byte address, channel c at [c*ADDR_W +: ADDR_W]
//   len_i             beats per enabled channel, latched at start
//   req_valid_o/req_ready_i/req_addr_o/req_ch_o   registered read-request port
//   rsp_valid_i       one beat response returned
//   busy_o            transfer in progress (INIT/EXEC/DONE)
//   done_o            one-cycle completion pulse
//   err_o             sticky: response seen with nothing outstanding
module expander_graph_dma_mc #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 16,
  parameter int BEAT_BYTES = 64,
  parameter int MAX_OUTST  = 8,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic [NUM_CH-1:0]        ch_en_i,
  input  logic [NUM_CH*ADDR_W-1:0] base_addr_i,
  input  logic [LEN_W-1:0]         len_i,
  output logic                     req_valid_o,
  input  logic                     req_ready_i,
  output logic [ADDR_W-1:0]        req_addr_o,
  output logic [CH_W-1:0]          req_ch_o,
  input  logic                     rsp_valid_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  localparam int OUT_W = $clog2(MAX_OUTST + 1);
  localparam int SHIFT = $clog2(BEAT_BYTES);

  typedef enum logic [1:0] {IDLE, INIT, EXEC, DONE} state_t;

  state_t              state_reg, state_next;
  logic [NUM_CH-1:0]   ch_en_reg;
  logic [ADDR_W-1:0]   base_reg   [NUM_CH];
  logic [ADDR_W-1:0]   base_in    [NUM_CH];
  logic [LEN_W-1:0]    len_reg;
  logic [LEN_W-1:0]    issued_reg [NUM_CH];
  logic [LEN_W-1:0]    issued_next[NUM_CH];
  logic [NUM_CH-1:0]   eligible, finished;
  logic [OUT_W-1:0]    outst_reg, outst_next;
  logic [CH_W-1:0]     rr_reg, rr_next;
  logic                req_valid_reg, req_valid_next;
  logic [ADDR_W-1:0]   req_addr_reg, req_addr_next;
  logic [CH_W-1:0]     req_ch_reg, req_ch_next;
  logic                err_reg;
  logic                hs, rsp_err, start_take;
  logic                pick_found;
  logic [CH_W-1:0]     pick_ch;
  logic [ADDR_W-1:0]   pick_addr;

  assign hs         = req_valid_reg & req_ready_i;
  assign start_take = (state_reg == IDLE) & start_i;

  // Eligibility is evaluated on the post-handshake issue counts so that a new
  // request can be registered in the same cycle the previous one is accepted.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign base_in[gi]     = base_addr_i[gi*ADDR_W +: ADDR_W];
    assign issued_next[gi] = issued_reg[gi] + LEN_W'(hs && (req_ch_reg == CH_W'(gi)));
    assign eligible[gi]    = ch_en_reg[gi] && (issued_next[gi] < len_reg);
    assign finished[gi]    = !ch_en_reg[gi] || (issued_reg[gi] == len_reg);
  end

  assign rr_next = !hs ? rr_reg :
                   (req_ch_reg == CH_W'(NUM_CH - 1)) ? '0 : req_ch_reg + CH_W'(1);

  // Outstanding bookkeeping; a simultaneous issue and return cancel out.
  always_comb begin
    outst_next = outst_reg;
    rsp_err    = 1'b0;
    if (hs && !rsp_valid_i) begin
      outst_next = outst_reg + OUT_W'(1);
    end else if (!hs && rsp_valid_i) begin
      if (outst_reg == '0) rsp_err = 1'b1;
      else                 outst_next = outst_reg - OUT_W'(1);
    end
  end

  // Round-robin: first eligible channel at or after the pointer, wrapping.
  always_comb begin
    int idx;
    pick_found = 1'b0;
    pick_ch    = rr_next;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(rr_next) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!pick_found && eligible[idx]) begin
        pick_found = 1'b1;
        pick_ch    = CH_W'(idx);
      end
    end
    pick_addr = base_reg[pick_ch] + (ADDR_W'(issued_next[pick_ch]) << SHIFT);
  end

  always_comb begin
    state_next     = state_reg;
    req_valid_next = 1'b0;
    req_addr_next  = req_addr_reg;
    req_ch_next    = req_ch_reg;
    case (state_reg)
      IDLE: if (start_i) state_next = INIT;
      INIT: begin
        if (len_reg == '0 || ch_en_reg == '0) begin
          state_next = DONE;
        end else begin
          state_next     = EXEC;
          req_valid_next = pick_found && (outst_next < OUT_W'(MAX_OUTST));
          req_addr_next  = pick_addr;
          req_ch_next    = pick_ch;
        end
      end
      EXEC: begin
        if ((&finished) && outst_reg == '0 && !hs) begin
          state_next = DONE;
        end else if (!req_valid_reg || hs) begin
          req_valid_next = pick_found && (outst_next < OUT_W'(MAX_OUTST));
          req_addr_next  = pick_addr;
          req_ch_next    = pick_ch;
        end else begin
          // Stalled by the consumer: hold the presented request unchanged.
          req_valid_next = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ch_en_reg     <= '0;
      len_reg       <= '0;
      outst_reg     <= '0;
      rr_reg        <= '0;
      req_valid_reg <= 1'b0;
      req_addr_reg  <= '0;
      req_ch_reg    <= '0;
      err_reg       <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        base_reg[c]   <= '0;
        issued_reg[c] <= '0;
      end
    end else begin
      state_reg     <= state_next;
      outst_reg     <= outst_next;
      rr_reg        <= rr_next;
      req_valid_reg <= req_valid_next;
      req_addr_reg  <= req_addr_next;
      req_ch_reg    <= req_ch_next;
      // A new start clears the sticky error, but a same-cycle bad response still sets it.
      err_reg       <= (err_reg & ~start_take) | rsp_err;
      if (start_take) begin
        ch_en_reg <= ch_en_i;
        len_reg   <= len_i;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (start_take) begin
          base_reg[c]   <= base_in[c];
          issued_reg[c] <= '0;
        end else begin
          issued_reg[c] <= issued_next[c];
        end
      end
    end
  end

  assign req_valid_o = req_valid_reg;
  assign req_addr_o  = req_addr_reg;
  assign req_ch_o    = req_ch_reg;
  assign busy_o      = (state_reg != IDLE);
  assign done_o      = (state_reg == DONE);
  assign err_o       = err_reg;

endmodule

// File: tb/tb_expander_graph_dma_mc.sv
// Scoreboard bench for expander_graph_dma_mc. Expected request streams are
// built from the round-robin rule at start time and queued; a negedge monitor
// pops and compares on every handshake and tracks outstanding/err behaviour.
module tb_expander_graph_dma_mc;

  localparam int NCH  = 4;
  localparam int MAXO = 3;

  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] addr;
  } req_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic [3:0]   ch_en_i;
  logic [127:0] base_addr_i;
  logic [15:0]  len_i;
  logic         req_valid_o;
  logic         req_ready_i;
  logic [31:0]  req_addr_o;
  logic [1:0]   req_ch_o;
  logic         rsp_valid_i;
  logic         busy_o, done_o, err_o;

  expander_graph_dma_mc #(.NUM_CH(NCH), .ADDR_W(32), .LEN_W(16), .BEAT_BYTES(64), .MAX_OUTST(MAXO)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .ch_en_i(ch_en_i),
    .base_addr_i(base_addr_i), .len_i(len_i), .req_valid_o(req_valid_o),
    .req_ready_i(req_ready_i), .req_addr_o(req_addr_o), .req_ch_o(req_ch_o),
    .rsp_valid_i(rsp_valid_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   hs_cnt = 0, done_cnt = 0;
  int   hs_mark, done_mark;
  int   model_outst = 0;
  int   model_rr = 0;
  bit   model_err = 1'b0;
  req_t exp_q[$];
  int   pend_q[$];
  int   ready_mode = 0;
  int   dly_min = 1, dly_max = 4;
  bit   rsp_en = 1'b1;
  bit   rsp_force = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ready driver.
  initial begin
    req_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       req_ready_i = 1'b1;
        1:       req_ready_i = ~req_ready_i;
        default: req_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Response driver: returns one beat per cycle once its due cycle arrives.
  initial begin
    bit auto_rsp;
    rsp_valid_i = 1'b0;
    forever begin
      @(posedge clk); #2;
      auto_rsp = 1'b0;
      if (rsp_en && pend_q.size() > 0 && pend_q[0] <= cyc) begin
        auto_rsp = 1'b1;
        void'(pend_q.pop_front());
      end
      rsp_valid_i = auto_rsp | rsp_force;
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit          hs, err_new, prev_hold;
    logic [31:0] prev_addr;
    logic [1:0]  prev_ch;
    req_t        e;
    int          due;
    prev_hold = 1'b0;
    prev_addr = '0;
    prev_ch   = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        exp_q.delete();
        pend_q.delete();
        model_outst = 0;
        model_err   = 1'b0;
        model_rr    = 0;
        prev_hold   = 1'b0;
      end else begin
        chk("err_o", err_o, model_err);
        hs = req_valid_o && req_ready_i;
        if (prev_hold) begin
          chk("hold_valid", req_valid_o, 1'b1);
          chk("hold_addr", req_addr_o, prev_addr);
          chk("hold_ch", req_ch_o, prev_ch);
        end
        if (hs) begin
          hs_cnt++;
          $display("req ch=%0d addr=%08h outst=%0d", req_ch_o, req_addr_o, model_outst);
          chk("outst_limit", model_outst < MAXO, 1'b1);
          if (exp_q.size() == 0) begin
            chk("unexpected_req", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            chk("req_ch", req_ch_o, e.ch);
            chk("req_addr", req_addr_o, e.addr);
          end
          due = cyc + int'($urandom_range(dly_min, dly_max));
          if (pend_q.size() > 0 && due <= pend_q[$]) due = pend_q[$] + 1;
          pend_q.push_back(due);
        end
        err_new = 1'b0;
        if (hs && !rsp_valid_i) model_outst++;
        else if (!hs && rsp_valid_i) begin
          if (model_outst == 0) err_new = 1'b1;
          else model_outst--;
        end
        if (start_i && !busy_o) model_err = 1'b0;
        model_err = model_err | err_new;
        if (done_o) done_cnt++;
        prev_hold = req_valid_o && !req_ready_i;
        prev_addr = req_addr_o;
        prev_ch   = req_ch_o;
      end
    end
  end

  // Build the expected stream: enabled channels in circular order from the
  // round-robin pointer, each beat index visiting every channel once.
  task automatic start_xfer(input logic [3:0] en, input logic [15:0] len, input logic [127:0] bases);
    int   order[$];
    int   guard = 0;
    req_t e;
    while (busy_o && guard < 1000) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    ch_en_i = en; len_i = len; base_addr_i = bases; start_i = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = (model_rr + k) % NCH;
      if (en[c]) order.push_back(c);
    end
    for (int j = 0; j < int'(len); j++) begin
      foreach (order[i]) begin
        e.ch   = 2'(order[i]);
        e.addr = bases[order[i]*32 +: 32] + 32'(j * 64);
        exp_q.push_back(e);
      end
    end
    if (order.size() > 0 && len != 0) model_rr = (order[order.size()-1] + 1) % NCH;
    @(posedge clk); #1;
    start_i = 1'b0;
    ch_en_i = 4'($urandom); len_i = 16'($urandom);
    base_addr_i = {$urandom, $urandom, $urandom, $urandom};
    hs_mark = hs_cnt; done_mark = done_cnt;
  endtask

  task automatic wait_done(input int maxc, output int n);
    n = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk); #1;
      if (done_o) begin n = i; break; end
    end
    chk("done_seen", n >= 0, 1'b1);
    if (n >= 0) begin
      chk("exp_q_drained", exp_q.size(), 0);
      chk("outst_at_done", model_outst, 0);
      @(negedge clk); #1;
      chk("busy_after_done", busy_o, 1'b0);
      chk("done_one_pulse", done_cnt - done_mark, 1);
    end
  endtask

  initial begin
    int n;
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; start_i = 1'b0; ch_en_i = '0; base_addr_i = '0; len_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", req_valid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    #2 rst_n = 1'b1;

    // 1: all channels, len 2, ready always, 3-cycle responses.
    dly_min = 3; dly_max = 3; ready_mode = 0;
    start_xfer(4'hF, 16'd2, {32'h3000, 32'h2000, 32'h1000, 32'h0000});
    wait_done(200, n);

    // 2: channels 0/2, len 3, ready toggling.
    dly_min = 1; dly_max = 4; ready_mode = 1;
    start_xfer(4'b0101, 16'd3, {32'h3000, 32'h2A00, 32'h1000, 32'h0100});
    wait_done(300, n);

    // 3: outstanding limit with responses withheld.
    ready_mode = 0; rsp_en = 1'b0;
    start_xfer(4'b0001, 16'd5, {96'h0, 32'h8000});
    repeat (20) @(negedge clk);
    #1;
    chk("limit_issued", hs_cnt - hs_mark, MAXO);
    chk("limit_valid_low", req_valid_o, 1'b0);
    chk("limit_not_done", busy_o, 1'b1);
    rsp_en = 1'b1;
    wait_done(300, n);

    // 4: zero-length and no-channel transfers go straight to DONE.
    start_xfer(4'hF, 16'd0, {4{32'h1234}});
    wait_done(20, n);
    chk("len0_latency", n, 1);
    chk("len0_no_req", hs_cnt - hs_mark, 0);
    start_xfer(4'h0, 16'd3, {4{32'h1234}});
    wait_done(20, n);
    chk("en0_latency", n, 1);
    chk("en0_no_req", hs_cnt - hs_mark, 0);

    // 5: address wrap, then a stray response sets err until the next start.
    start_xfer(4'b0001, 16'd2, {96'h0, 32'hFFFFFFC0});
    wait_done(100, n);
    @(posedge clk); #1 rsp_force = 1'b1;
    @(posedge clk); #1 rsp_force = 1'b0;
    repeat (4) @(negedge clk);
    #1 chk("stray_err_sticky", err_o, 1'b1);
    start_xfer(4'b0010, 16'd1, {64'h0, 32'h400, 32'h0});
    #5 chk("err_cleared_by_start", err_o, 1'b0);
    wait_done(100, n);

    // 6: asynchronous reset mid-transfer with 3 outstanding.
    rsp_en = 1'b0;
    start_xfer(4'hF, 16'd4, {32'h3000, 32'h2000, 32'h1000, 32'h0000});
    n = 0;
    while (hs_cnt - hs_mark < MAXO && n < 100) begin @(negedge clk); n++; end
    chk("pre_reset_outst", hs_cnt - hs_mark, MAXO);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", req_valid_o, 1'b0);
    chk("async_rst_busy", busy_o, 1'b0);
    chk("async_rst_done", done_o, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    rsp_en = 1'b1;
    @(posedge clk); #1 rsp_force = 1'b1;
    @(posedge clk); #1 rsp_force = 1'b0;
    @(negedge clk); #1 chk("late_rsp_err", err_o, 1'b1);
    start_xfer(4'b1001, 16'd2, {32'h7000, 64'h0, 32'h5000});
    wait_done(200, n);

    // Randomised transfers.
    for (int t = 0; t < 12; t++) begin
      ready_mode = int'($urandom_range(0, 2));
      dly_min = 1; dly_max = int'($urandom_range(1, 6));
      start_xfer(4'($urandom), 16'($urandom_range(0, 6)),
                 {$urandom, $urandom, $urandom, $urandom});
      wait_done(1000, n);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
